// File: rtl/udp_demux_pkg.sv
// -----------------------------------------------------------------------------
// udp_demux_pkg
// Shared definitions for the UDP port demultiplexer and its port matcher:
// dispatcher state encoding, UDP port / byte widths, and a helper that pulls
// one 16-bit entry out of a flattened port table.
// -----------------------------------------------------------------------------
package udp_demux_pkg;

    localparam int UDP_PORT_W = 16;
    localparam int BYTE_W     = 8;
    localparam int MAX_CH     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } demux_state_t;

    // Entry idx of a port table that has been zero-extended to MAX_CH entries.
    function automatic logic [UDP_PORT_W-1:0] port_entry(
        input logic [MAX_CH*UDP_PORT_W-1:0] tbl,
        input int                           idx
    );
        return tbl[idx*UDP_PORT_W +: UDP_PORT_W];
    endfunction

endpackage

// File: rtl/udp_port_match.sv
// -----------------------------------------------------------------------------
// udp_port_match
// Purely combinational priority match of a UDP port against a port table,
// qualified by a per-entry enable mask. The lowest matching index wins.
//
// Ports:
//   i_port    in  16              port to look up
//   i_table   in  NUM_CH*16       port table, entry i at [16*i +: 16]
//   i_enable  in  NUM_CH          per-entry enable
//   o_hit     out 1               at least one enabled entry matched
//   o_idx     out IDX_W           index of the lowest matching entry (0 if none)
// -----------------------------------------------------------------------------
module udp_port_match
    import udp_demux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [UDP_PORT_W-1:0]        i_port,
    input  logic [NUM_CH*UDP_PORT_W-1:0] i_table,
    input  logic [NUM_CH-1:0]            i_enable,
    output logic                         o_hit,
    output logic [IDX_W-1:0]             o_idx
);

    logic [MAX_CH*UDP_PORT_W-1:0] w_table_ext;

    assign w_table_ext = (MAX_CH*UDP_PORT_W)'(i_table);

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_enable[i] && (port_entry(w_table_ext, i) == i_port)) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/udp_rx_port_demux.sv
// -----------------------------------------------------------------------------
// udp_rx_port_demux
// Routes UDP payload bytes from the receive engine to one of NUM_CH channels,
// chosen by destination port against PORT_LIST and the ch_enable mask captured
// at packet start. Bytes appear on the selected lane one cycle after input,
// marked first/last; length mismatches and aborted packets pulse ch_len_err.
// Unmatched packets are dropped and counted; dispatched packets are counted
// per channel. All counters saturate.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rx_pkt_start / _done        one-cycle packet start / end pulses
//   rx_pkt_en, rx_pkt_data      payload byte strobe and byte
//   rx_pkt_dest_port            destination port (sampled with start)
//   rx_pkt_byte_num             payload length (sampled with start)
//   ch_enable                   per-channel accept mask (sampled with start)
//   ch_tvalid/tdata/tfirst/tlast  per-channel byte stream
//   ch_len_err                  per-channel length error pulse
//   ch_pkt_cnt, drop_cnt        saturating packet counters
//   busy                        dispatcher not idle
// -----------------------------------------------------------------------------
module udp_rx_port_demux
    import udp_demux_pkg::*;
#(
    parameter int                          NUM_CH    = 4,
    parameter logic [NUM_CH*UDP_PORT_W-1:0] PORT_LIST = {16'd8080, 16'd5000, 16'd1235, 16'd1234},
    parameter int                          CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_pkt_start,
    input  logic                     rx_pkt_en,
    input  logic [BYTE_W-1:0]        rx_pkt_data,
    input  logic [UDP_PORT_W-1:0]    rx_pkt_dest_port,
    input  logic [15:0]              rx_pkt_byte_num,
    input  logic                     rx_pkt_done,
    input  logic [NUM_CH-1:0]        ch_enable,
    output logic [NUM_CH-1:0]        ch_tvalid,
    output logic [NUM_CH*BYTE_W-1:0] ch_tdata,
    output logic [NUM_CH-1:0]        ch_tfirst,
    output logic [NUM_CH-1:0]        ch_tlast,
    output logic [NUM_CH-1:0]        ch_len_err,
    output logic [NUM_CH*CNT_W-1:0]  ch_pkt_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     busy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    demux_state_t             r_state;
    logic [IDX_W-1:0]         r_ch_sel;
    logic [15:0]              r_exp_len;
    logic [15:0]              r_cnt;
    logic                     r_ovf;

    logic [NUM_CH-1:0]        r_tvalid;
    logic [NUM_CH*BYTE_W-1:0] r_tdata;
    logic [NUM_CH-1:0]        r_tfirst;
    logic [NUM_CH-1:0]        r_tlast;
    logic [NUM_CH-1:0]        r_len_err;
    logic [CNT_W-1:0]         r_pkt_cnt [NUM_CH];
    logic [CNT_W-1:0]         r_drop_cnt;

    logic                     w_hit;
    logic [IDX_W-1:0]         w_idx;

    demux_state_t             w_state_nxt;
    logic [IDX_W-1:0]         w_sel_nxt;
    logic [15:0]              w_exp_nxt;
    logic [15:0]              w_cnt_nxt;
    logic                     w_ovf_nxt;
    logic                     w_fwd;
    logic                     w_first;
    logic                     w_last;
    logic                     w_inc_pkt;
    logic                     w_inc_drop;
    logic [NUM_CH-1:0]        w_err_vec;

    logic [NUM_CH-1:0]        w_sel_oh;
    logic [NUM_CH*BYTE_W-1:0] w_tdata_nxt;

    udp_port_match #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_match (
        .i_port   (rx_pkt_dest_port),
        .i_table  (PORT_LIST),
        .i_enable (ch_enable),
        .o_hit    (w_hit),
        .o_idx    (w_idx)
    );

    // Next-state logic. A start is resolved first (aborting any open packet),
    // then the byte and done of the same cycle are applied to the resulting
    // packet context, so a coincident byte belongs to the new packet and a
    // coincident done sees the byte already counted.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_ch_sel;
        w_exp_nxt   = r_exp_len;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_fwd       = 1'b0;
        w_first     = 1'b0;
        w_last      = 1'b0;
        w_inc_pkt   = 1'b0;
        w_inc_drop  = 1'b0;
        w_err_vec   = '0;

        if (rx_pkt_start) begin
            if (r_state == ST_FWD) begin
                w_err_vec[r_ch_sel] = 1'b1;
            end
            if (w_hit) begin
                w_sel_nxt   = w_idx;
                w_exp_nxt   = rx_pkt_byte_num;
                w_cnt_nxt   = '0;
                w_ovf_nxt   = 1'b0;
                w_inc_pkt   = 1'b1;
                w_state_nxt = ST_FWD;
            end else begin
                w_inc_drop  = 1'b1;
                w_state_nxt = ST_DROP;
            end
        end

        case (w_state_nxt)
            ST_FWD: begin
                if (rx_pkt_en) begin
                    if (w_cnt_nxt < w_exp_nxt) begin
                        w_fwd     = 1'b1;
                        w_first   = (w_cnt_nxt == 16'd0);
                        w_last    = (w_cnt_nxt == w_exp_nxt - 16'd1);
                        w_cnt_nxt = w_cnt_nxt + 16'd1;
                    end else begin
                        w_ovf_nxt = 1'b1;
                    end
                end
                if (rx_pkt_done) begin
                    if ((w_cnt_nxt != w_exp_nxt) || w_ovf_nxt) begin
                        w_err_vec[w_sel_nxt] = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (rx_pkt_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    // Output lane steering: only the selected lane carries data.
    always_comb begin
        w_sel_oh    = '0;
        w_tdata_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_fwd && (w_sel_nxt == IDX_W'(i))) begin
                w_sel_oh[i]                     = 1'b1;
                w_tdata_nxt[i*BYTE_W +: BYTE_W] = rx_pkt_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ch_sel   <= '0;
            r_exp_len  <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_tvalid   <= '0;
            r_tdata    <= '0;
            r_tfirst   <= '0;
            r_tlast    <= '0;
            r_len_err  <= '0;
            r_drop_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_pkt_cnt[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_ch_sel  <= w_sel_nxt;
            r_exp_len <= w_exp_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ovf     <= w_ovf_nxt;
            r_tvalid  <= w_sel_oh;
            r_tdata   <= w_tdata_nxt;
            r_tfirst  <= w_first ? w_sel_oh : '0;
            r_tlast   <= w_last ? w_sel_oh : '0;
            r_len_err <= w_err_vec;
            if (w_inc_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_inc_pkt && (w_sel_nxt == IDX_W'(i)) && (r_pkt_cnt[i] != '1)) begin
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign ch_tvalid  = r_tvalid;
    assign ch_tdata   = r_tdata;
    assign ch_tfirst  = r_tfirst;
    assign ch_tlast   = r_tlast;
    assign ch_len_err = r_len_err;
    assign drop_cnt   = r_drop_cnt;
    assign busy       = (r_state != ST_IDLE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
        assign ch_pkt_cnt[g*CNT_W +: CNT_W] = r_pkt_cnt[g];
    end

endmodule
